// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one ALU between two valid/ready requesters
module alu_arbiter #(
  parameter int ALU_WAIT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid_0,
  output logic       req_ready_0,
  input  logic [5:0] req_op_0,
  input  logic [7:0] req_a_0,
  input  logic [7:0] req_b_0,
  input  logic       req_valid_1,
  output logic       req_ready_1,
  input  logic [5:0] req_op_1,
  input  logic [7:0] req_a_1,
  input  logic [7:0] req_b_1,
  output logic       rsp_valid_0,
  input  logic       rsp_ready_0,
  output logic       rsp_valid_1,
  input  logic       rsp_ready_1,
  output logic [7:0] rsp_result,
  output logic       rsp_err,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [5:0] alu_op,
  input  logic [7:0] alu_result,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t     state;
  logic [3:0] cnt;
  logic       last_grant, owner, sel, take, bad;
  logic [5:0] op_in;
  logic [7:0] a_in, b_in;
  always_comb begin
    sel   = (req_valid_0 && req_valid_1) ? ~last_grant : req_valid_1;
    take  = (state == IDLE) && (req_valid_0 || req_valid_1);
    op_in = sel ? req_op_1 : req_op_0;
    a_in  = sel ? req_a_1 : req_a_0;
    b_in  = sel ? req_b_1 : req_b_0;
    bad   = !(op_in inside {6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h10, 6'h11})
            || (op_in == 6'h03 && b_in == 8'd0)
            || ((op_in == 6'h10 || op_in == 6'h11) && b_in > 8'd7);
  end
  assign req_ready_0 = take && !sel;
  assign req_ready_1 = take && sel;
  assign rsp_valid_0 = (state == RESP) && !owner;
  assign rsp_valid_1 = (state == RESP) && owner;
  assign busy        = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
    end else begin
      case (state)
        IDLE: if (take) begin
          owner      <= sel;
          last_grant <= sel;
          if (bad) begin
            state      <= RESP;
            rsp_err    <= 1'b1;
            rsp_result <= '0;
          end else begin
            state  <= EXEC;
            cnt    <= 4'(ALU_WAIT - 1);
            alu_a  <= a_in;
            alu_b  <= b_in;
            alu_op <= op_in;
          end
        end
        EXEC: if (cnt == 4'd0) begin
          state      <= RESP;
          rsp_result <= alu_result;
          rsp_err    <= 1'b0;
        end else cnt <= cnt - 4'd1;
        RESP: if (owner ? rsp_ready_1 : rsp_ready_0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of alu_arbiter with ALU_WAIT=2 and ALU_WAIT=4 instances
module tb_alu_arbiter;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       v0 = 0, v1 = 0, rr0 = 1, rr1 = 1;
  logic [5:0] op0 = 0, op1 = 0;
  logic [7:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic       ready0, ready1, rv0, rv1, err, busy;
  logic [7:0] result, alu_a, alu_b, alu_res;
  logic [5:0] alu_op;
  logic       qv = 0, q_ready, q_ready1, q_rv, q_rv1, q_err, q_busy;
  logic [5:0] q_op = 0, q_alu_op;
  logic [7:0] q_a = 0, q_b = 0, q_result, q_alu_a, q_alu_b, q_alu_res;
  int checks = 0, failures = 0, n;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      6'h00: return a + b;
      6'h01: return a - b;
      6'h02: return 8'(a * b);
      6'h03: return b == 0 ? 8'h00 : a / b;
      6'h04: return a < b ? 8'h01 : 8'h00;
      6'h08: return ~a;
      6'h09: return a & b;
      6'h0a: return a | b;
      6'h0b: return a ^ b;
      6'h10: return a << b[2:0];
      6'h11: return a >> b[2:0];
      default: return 8'h00;
    endcase
  endfunction

  assign alu_res   = alu_f(alu_op, alu_a, alu_b);
  assign q_alu_res = alu_f(q_alu_op, q_alu_a, q_alu_b);

  alu_arbiter #(.ALU_WAIT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(v0), .req_ready_0(ready0), .req_op_0(op0), .req_a_0(a0), .req_b_0(b0),
    .req_valid_1(v1), .req_ready_1(ready1), .req_op_1(op1), .req_a_1(a1), .req_b_1(b1),
    .rsp_valid_0(rv0), .rsp_ready_0(rr0), .rsp_valid_1(rv1), .rsp_ready_1(rr1),
    .rsp_result(result), .rsp_err(err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_res), .busy(busy)
  );

  alu_arbiter #(.ALU_WAIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(qv), .req_ready_0(q_ready), .req_op_0(q_op), .req_a_0(q_a), .req_b_0(q_b),
    .req_valid_1(1'b0), .req_ready_1(q_ready1), .req_op_1(6'h00), .req_a_1(8'h00), .req_b_1(8'h00),
    .rsp_valid_0(q_rv), .rsp_ready_0(1'b1), .rsp_valid_1(q_rv1), .rsp_ready_1(1'b1),
    .rsp_result(q_result), .rsp_err(q_err),
    .alu_a(q_alu_a), .alu_b(q_alu_b), .alu_op(q_alu_op), .alu_result(q_alu_res), .busy(q_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(output int cnt);
    cnt = 0;
    while (!(rv0 || rv1) && cnt < 20) begin
      cyc();
      cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    cyc();
    cyc();
    chk("rst_busy", busy, 0);
    chk("rst_rv0", rv0, 0);
    chk("rst_rv1", rv1, 0);
    chk("rst_result", result, 0);
    chk("rst_err", err, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_ready0", ready0, 0);
    chk("rst4_busy", q_busy, 0);
    // single add request, latency ALU_WAIT
    rst_n = 1;
    v0 = 1; op0 = 6'h00; a0 = 8'd5; b0 = 8'd3;
    #1;
    chk("add_ready0", ready0, 1);
    chk("add_ready1", ready1, 0);
    cyc();
    v0 = 0; a0 = 8'hff;
    chk("add_alu_op", alu_op, 6'h00);
    chk("add_alu_a", alu_a, 8'd5);
    chk("add_alu_b", alu_b, 8'd3);
    chk("add_busy", busy, 1);
    wait_rsp(n);
    chk("add_lat", n, 2);
    chk("add_rv0", rv0, 1);
    chk("add_rv1", rv1, 0);
    chk("add_result", result, 8'h08);
    chk("add_err", err, 0);
    chk("add_ready1_resp", ready1, 0);
    cyc();
    chk("add_idle", busy, 0);
    // tie after reset: 0 first then alternating
    rst_n = 0;
    cyc();
    rst_n = 1;
    v0 = 1; op0 = 6'h01; a0 = 8'd9; b0 = 8'd4;
    v1 = 1; op1 = 6'h0b; a1 = 8'hf0; b1 = 8'h3c;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_ready1", ready1, i % 2);
      chk("rr_ready0", ready0, (i + 1) % 2);
      cyc();
      if (i == 0) chk("rr_busy_ready0", ready0, 0);
      wait_rsp(n);
      chk("rr_lat", n, 2);
      chk("rr_rv1", rv1, i % 2);
      chk("rr_result", result, (i % 2) ? 8'hcc : 8'h05);
      cyc();
    end
    v0 = 0; v1 = 0;
    // rejected requests on port 1
    for (int k = 0; k < 3; k++) begin
      v1 = 1; a1 = 8'd7;
      op1 = (k == 0) ? 6'h03 : (k == 1) ? 6'h07 : 6'h10;
      b1 = (k == 0) ? 8'd0 : (k == 1) ? 8'd1 : 8'd8;
      #1;
      chk("err_ready1", ready1, 1);
      cyc();
      v1 = 0;
      wait_rsp(n);
      chk("err_lat", n, 0);
      chk("err_rv1", rv1, 1);
      chk("err_rv0", rv0, 0);
      chk("err_flag", err, 1);
      chk("err_result", result, 0);
      chk("err_alu_op", alu_op, 6'h0b);
      chk("err_alu_a", alu_a, 8'hf0);
      cyc();
    end
    // backpressure with pending req1
    rr0 = 0;
    v0 = 1; op0 = 6'h02; a0 = 8'd3; b0 = 8'd4;
    v1 = 1; op1 = 6'h0b; a1 = 8'd1; b1 = 8'd2;
    #1;
    chk("bp_ready0", ready0, 1);
    cyc();
    v0 = 0;
    wait_rsp(n);
    chk("bp_lat", n, 2);
    chk("bp_rv0", rv0, 1);
    chk("bp_result", result, 8'h0c);
    for (int j = 0; j < 5; j++) begin
      cyc();
      chk("bp_hold_rv0", rv0, 1);
      chk("bp_hold_result", result, 8'h0c);
      chk("bp_hold_ready1", ready1, 0);
      chk("bp_hold_rv1", rv1, 0);
    end
    rr0 = 1;
    #1;
    chk("bp_hs_ready1", ready1, 0);
    cyc();
    chk("bp_next_ready1", ready1, 1);
    cyc();
    v1 = 0;
    wait_rsp(n);
    chk("bp_rv1", rv1, 1);
    chk("bp_result1", result, 8'h03);
    cyc();
    // reset during EXEC
    v0 = 1; op0 = 6'h09; a0 = 8'hf0; b0 = 8'h3c;
    cyc();
    v0 = 0;
    cyc();
    chk("mid_busy_pre", busy, 1);
    rst_n = 0;
    cyc();
    rst_n = 1;
    chk("mid_busy", busy, 0);
    chk("mid_rv0", rv0, 0);
    chk("mid_result", result, 0);
    chk("mid_err", err, 0);
    chk("mid_alu_op", alu_op, 0);
    chk("mid_alu_a", alu_a, 0);
    chk("mid_alu_b", alu_b, 0);
    v1 = 1; op1 = 6'h00; a1 = 8'd1; b1 = 8'd1;
    #1;
    chk("mid_ready1", ready1, 1);
    cyc();
    v1 = 0;
    wait_rsp(n);
    chk("mid_rv1", rv1, 1);
    chk("mid_rv0_none", rv0, 0);
    chk("mid_result1", result, 8'h02);
    cyc();
    // ALU_WAIT=4 instance, shr
    qv = 1; q_op = 6'h11; q_a = 8'h80; q_b = 8'd3;
    #1;
    chk("w4_ready", q_ready, 1);
    cyc();
    qv = 0; q_a = 8'h00;
    n = 0;
    while (!q_rv && n < 20) begin
      chk("w4_alu_a", q_alu_a, 8'h80);
      chk("w4_alu_b", q_alu_b, 8'd3);
      chk("w4_alu_op", q_alu_op, 6'h11);
      cyc();
      n++;
    end
    chk("w4_lat", n, 4);
    chk("w4_result", q_result, 8'h10);
    chk("w4_err", q_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
